// File: rtl/seg7_pkg.sv
// Shared types and segment codes for the multiplexed seven-segment driver.
// Codes are active-high {g,f,e,d,c,b,a}; polarity is applied at the pins.
package seg7_pkg;

    typedef logic [6:0] seg7_t;

    localparam int NUM_DIGITS = 8;

    localparam seg7_t SEG_0   = 7'h3F;
    localparam seg7_t SEG_1   = 7'h06;
    localparam seg7_t SEG_2   = 7'h5B;
    localparam seg7_t SEG_3   = 7'h4F;
    localparam seg7_t SEG_4   = 7'h66;
    localparam seg7_t SEG_5   = 7'h6D;
    localparam seg7_t SEG_6   = 7'h7D;
    localparam seg7_t SEG_7   = 7'h07;
    localparam seg7_t SEG_8   = 7'h7F;
    localparam seg7_t SEG_9   = 7'h6F;
    localparam seg7_t SEG_A   = 7'h77;
    localparam seg7_t SEG_B   = 7'h7C;
    localparam seg7_t SEG_C   = 7'h39;
    localparam seg7_t SEG_D   = 7'h5E;
    localparam seg7_t SEG_E   = 7'h79;
    localparam seg7_t SEG_F   = 7'h71;
    localparam seg7_t SEG_OFF = 7'h00;

    function automatic seg7_t hex_seg(input logic [3:0] nib);
        seg7_t s;
        s = SEG_OFF;
        case (nib)
            4'h0: s = SEG_0;
            4'h1: s = SEG_1;
            4'h2: s = SEG_2;
            4'h3: s = SEG_3;
            4'h4: s = SEG_4;
            4'h5: s = SEG_5;
            4'h6: s = SEG_6;
            4'h7: s = SEG_7;
            4'h8: s = SEG_8;
            4'h9: s = SEG_9;
            4'hA: s = SEG_A;
            4'hB: s = SEG_B;
            4'hC: s = SEG_C;
            4'hD: s = SEG_D;
            4'hE: s = SEG_E;
            4'hF: s = SEG_F;
            default: s = SEG_OFF;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/seg7_scan_display_hex_to_seg7.sv
// Combinational hex nibble to active-high segment pattern.
// Blanking and pin polarity are handled by the caller.
module hex_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] i_nib,
    output seg7_t      o_seg
);

    assign o_seg = hex_seg(i_nib);

endmodule

// File: rtl/seg7_scan_display.sv
// Eight-digit multiplexed hex display with per-frame snapshot,
// inter-digit anode blanking and optional leading-zero suppression.
module seg7_scan_display
    import seg7_pkg::*;
#(
    parameter int SCAN_DIV       = 100000,
    parameter int BLANK_CYC      = 2,
    parameter int SEG_ACTIVE_LOW = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [31:0]           led_data,
    input  logic                  blank_lz,
    input  logic [7:0]            dp_mask,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [NUM_DIGITS-1:0] an,
    output logic                  frame_tick
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(SCAN_DIV - 1);
    localparam logic [PW-1:0] BLANK_LIM = PW'(BLANK_CYC);
    localparam logic INV = (SEG_ACTIVE_LOW != 0);
    localparam logic [7:0] AN_IDLE = {8{INV}};
    localparam logic [6:0] SEG_IDLE = {7{INV}};

    logic [PW-1:0] r_pre;
    logic [2:0]    r_idx;
    logic [31:0]   r_snap;
    logic [7:0]    r_snap_dp;
    logic          r_tick;
    logic [7:0]    r_an;
    logic [6:0]    r_seg;
    logic          r_dp;

    logic          w_wrap;
    logic [4:0]    w_shamt;
    logic [3:0]    w_nib;
    logic [31:0]   w_hi;
    logic          w_blank;
    logic          w_active;
    seg7_t         w_raw;
    logic [7:0]    w_an_hi;
    logic [6:0]    w_seg_hi;
    logic          w_dp_hi;

    assign w_wrap   = (r_pre == PRE_MAX);
    assign w_shamt  = {r_idx, 2'b00};
    assign w_nib    = r_snap[w_shamt +: 4];
    assign w_hi     = r_snap >> w_shamt;
    assign w_blank  = blank_lz && (r_idx != 3'd0) && (w_hi == '0);
    assign w_active = (r_pre >= BLANK_LIM);

    hex_to_seg7 u_dec (
        .i_nib (w_nib),
        .o_seg (w_raw)
    );

    // Slot prescaler and digit index advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pre <= '0;
            r_idx <= 3'd0;
        end else if (w_wrap) begin
            r_pre <= '0;
            r_idx <= r_idx + 3'd1;
        end else begin
            r_pre <= r_pre + 1'b1;
        end
    end

    // Capture the display word at the end of digit 7 so a frame never tears.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_snap    <= '0;
            r_snap_dp <= '0;
            r_tick    <= 1'b0;
        end else begin
            r_tick <= w_wrap && (r_idx == 3'd7);
            if (w_wrap && (r_idx == 3'd7)) begin
                r_snap    <= led_data;
                r_snap_dp <= dp_mask;
            end
        end
    end

    // Active-high view of the next pin state; everything dark while blanking.
    always_comb begin
        w_an_hi  = 8'h00;
        w_seg_hi = SEG_OFF;
        w_dp_hi  = 1'b0;
        if (w_active) begin
            w_an_hi  = 8'b1 << r_idx;
            w_seg_hi = w_blank ? SEG_OFF : w_raw;
            w_dp_hi  = r_snap_dp[r_idx];
        end
    end

    // Registered pin stage with board polarity applied.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_an  <= AN_IDLE;
            r_seg <= SEG_IDLE;
            r_dp  <= INV;
        end else begin
            r_an  <= w_an_hi ^ AN_IDLE;
            r_seg <= w_seg_hi ^ SEG_IDLE;
            r_dp  <= w_dp_hi ^ INV;
        end
    end

    assign an         = r_an;
    assign seg        = r_seg;
    assign dp         = r_dp;
    assign frame_tick = r_tick;

endmodule

// File: tb/tb_seg7_scan_display.sv
// Scoreboard bench for seg7_scan_display (SCAN_DIV=4, BLANK_CYC=1, active-low).
// The driver queues the expected pin state per cycle; the monitor checks it.
module tb_seg7_scan_display;

    logic        clk;
    logic        rst_n;
    logic [31:0] led_data;
    logic        blank_lz;
    logic [7:0]  dp_mask;
    logic [6:0]  seg;
    logic        dp;
    logic [7:0]  an;
    logic        frame_tick;

    seg7_scan_display #(
        .SCAN_DIV       (4),
        .BLANK_CYC      (1),
        .SEG_ACTIVE_LOW (1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .led_data   (led_data),
        .blank_lz   (blank_lz),
        .dp_mask    (dp_mask),
        .seg        (seg),
        .dp         (dp),
        .an         (an),
        .frame_tick (frame_tick)
    );

    typedef struct {
        int unsigned cyc;
        logic [7:0]  an;
        logic [6:0]  seg;
        logic        dp;
        logic        tick;
        logic        seg_chk;
        string       name;
    } exp_t;

    exp_t q[$];

    logic [6:0] tbl [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    int unsigned cyc = 0;
    int          n_chk = 0;
    int          n_pass = 0;
    int unsigned r = 0;
    logic [31:0] m_snap = '0;
    logic [7:0]  m_dp = '0;
    string       cur_name = "reset";

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1, "timeout");
    end

    // Monitor: pops every expectation whose cycle has arrived.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (q.size() > 0 && q[0].cyc <= cyc) begin
                e = q.pop_front();
                n_chk++;
                if (e.cyc < cyc) begin
                    $display("FAIL %s missed: got cyc=%0d want cyc=%0d",
                             e.name, cyc, e.cyc);
                end else if (an == e.an && dp == e.dp &&
                             frame_tick == e.tick &&
                             (!e.seg_chk || seg == e.seg)) begin
                    n_pass++;
                end else begin
                    $display("FAIL %s cyc=%0d an=%h want %h seg=%h want %h dp=%b want %b tick=%b want %b",
                             e.name, cyc, an, e.an, seg, e.seg, dp, e.dp,
                             frame_tick, e.tick);
                end
            end
        end
    end

    task automatic push_rst(input int unsigned c, input string nm);
        exp_t e;
        e.cyc = c; e.an = 8'hFF; e.seg = 7'h7F; e.dp = 1'b1;
        e.tick = 1'b0; e.seg_chk = 1'b1; e.name = nm;
        q.push_back(e);
    endtask

    task automatic rst_hold(input int n);
        for (int i = 0; i < n; i++) begin
            push_rst(cyc + 1, "reset_hold");
            @(negedge clk);
        end
    endtask

    // One cycle: called just after a negedge with r edges since release.
    task automatic step(input logic [31:0] d, input logic [7:0] dm,
                        input logic bz);
        exp_t        e;
        int unsigned pre;
        int unsigned idx;
        logic        act;
        logic        blk;
        logic [31:0] hi;
        logic [3:0]  nib;
        if (r > 0 && r % 32 == 0) begin
            m_snap = led_data;
            m_dp   = dp_mask;
        end
        led_data = d;
        dp_mask  = dm;
        blank_lz = bz;
        pre = r % 4;
        idx = (r / 4) % 8;
        act = (pre >= 1);
        hi  = m_snap >> (4 * idx);
        nib = hi[3:0];
        blk = bz && (idx != 0) && (hi == 0);
        e.cyc     = cyc + 1;
        e.an      = act ? ~(8'b1 << idx) : 8'hFF;
        e.seg     = (act && !blk) ? ~tbl[nib] : 7'h7F;
        e.dp      = !(act && m_dp[idx]);
        e.tick    = ((r + 1) % 32 == 0);
        e.seg_chk = act;
        e.name    = cur_name;
        q.push_back(e);
        @(negedge clk);
        r++;
    endtask

    task automatic run(input int n, input logic [31:0] d,
                       input logic [7:0] dm, input logic bz);
        for (int i = 0; i < n; i++) step(d, dm, bz);
    endtask

    initial begin
        rst_n    = 1'b0;
        led_data = 32'h12345678;
        blank_lz = 1'b0;
        dp_mask  = 8'h00;
        @(negedge clk);
        rst_hold(3);
        rst_n = 1'b1;
        r = 0;

        cur_name = "reset_release";
        run(64, 32'h12345678, 8'h00, 1'b0);

        cur_name = "scan_deadbeef";
        run(64, 32'hDEADBEEF, 8'h00, 1'b0);

        cur_name = "tear_zero";
        run(32, 32'h00000000, 8'h00, 1'b0);
        run(14, 32'h00000000, 8'h00, 1'b0);
        cur_name = "tear_change";
        run(50, 32'hFFFFFFFF, 8'h00, 1'b0);

        cur_name = "lz_a0";
        run(64, 32'h000000A0, 8'h00, 1'b1);
        cur_name = "lz_zero";
        run(64, 32'h00000000, 8'h00, 1'b1);

        cur_name = "dp_81";
        run(64, 32'h12345678, 8'h81, 1'b0);

        cur_name = "pre_midreset";
        run(20, 32'h12345678, 8'h81, 1'b0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        push_rst(cyc, "rst_async");
        @(negedge clk);
        rst_hold(2);
        rst_n  = 1'b1;
        r      = 0;
        m_snap = '0;
        m_dp   = '0;
        cur_name = "after_midreset";
        run(72, 32'h87654321, 8'h81, 1'b0);

        repeat (3) @(negedge clk);
        while (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            n_chk++;
            $display("FAIL %s never checked: got none want cyc=%0d",
                     e.name, e.cyc);
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
